xip_line_cache: RTL and testbench

Direct-mapped, read-only line cache that sits directly upstream of the QSPI XIP flash controller. It serves 32-bit word reads from a simple request/ready bus. On a miss it issues one line-fill request to the controller and waits for completion. It then stores the returned line and answers the pending read from it.

---
 rtl/xip_line_cache.sv | 122 ++++++++++++
 tb/tb_xip_line_cache.sv | 132 +++++++++++++
 2 files changed

// File: rtl/xip_line_cache.sv
// xip_line_cache: direct-mapped, read-only line cache in front of the QSPI XIP flash controller.
// Optional hit/miss statistics counters are built when XIP_CACHE_STATS_EN is defined.
module xip_line_cache #(
   parameter int NUM_LINES     = 16,
   parameter int LINE_SIZE     = 16,
   parameter int CAPTURE_DELAY = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req,
   input  logic [23:0]            addr,
   output logic                   ready,
   output logic [31:0]            rdata,
   input  logic                   flush,
   output logic                   fill_rd,
   output logic [23:0]            fill_addr,
   input  logic                   fill_done,
   input  logic [LINE_SIZE*8-1:0] fill_line
`ifdef XIP_CACHE_STATS_EN
   ,
   output logic [31:0]            hit_count,
   output logic [31:0]            miss_count
`endif
);
   localparam int OFF = $clog2(LINE_SIZE);
   localparam int IDX = $clog2(NUM_LINES);
   localparam int TW  = 24 - OFF - IDX;
   localparam int CW  = $clog2(CAPTURE_DELAY + 2);
   typedef enum logic [2:0] {IDLE, FILL, WAIT, CAPT, RESP} state_t;
   state_t                 state, state_nx;
   logic [NUM_LINES-1:0]   valid;
   logic [TW-1:0]          tags [NUM_LINES];
   logic [LINE_SIZE*8-1:0] lines [NUM_LINES];
   logic [CW-1:0]          cnt;
   logic                   poison;
   logic [IDX-1:0]         idx, fidx;
   logic [OFF+2:0]         rbit;
   logic                   lookup_hit, hit, miss, capture;
   assign idx  = addr[OFF+IDX-1:OFF];
   assign fidx = fill_addr[OFF+IDX-1:OFF];
   // bit offset of the addressed 32-bit word inside a line (addr is held stable through a fill)
   assign rbit = {addr[OFF-1:0] & ~OFF'(3), 3'b000};
   // a same-cycle flush wins over the lookup, so it forces a miss
   assign lookup_hit = !flush && valid[idx] && tags[idx] == addr[23:OFF+IDX];
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   // next-state and per-state control strobes
   always_comb begin
      state_nx = state;
      fill_rd  = 1'b0;
      ready    = 1'b0;
      hit      = 1'b0;
      miss     = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: if (req) begin
            hit      = lookup_hit;
            miss     = !lookup_hit;
            state_nx = lookup_hit ? RESP : FILL;
         end
         FILL: begin
            fill_rd  = 1'b1;
            state_nx = WAIT;
         end
         WAIT: state_nx = fill_done ? CAPT : WAIT;
         CAPT: if (cnt <= CW'(1)) begin
            capture  = 1'b1;
            state_nx = RESP;
         end
         RESP: begin
            ready    = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   // valid bits, fill bookkeeping, capture delay and the registered read word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid     <= '0;
         rdata     <= '0;
         fill_addr <= '0;
         cnt       <= '0;
         poison    <= 1'b0;
      end else begin
         if (flush)                  valid       <= '0;
         else if (capture && !poison) valid[fidx] <= 1'b1;
         if (miss) begin
            fill_addr <= {addr[23:OFF], OFF'(0)};
            poison    <= 1'b0;
         end else if (flush && (state == FILL || state == WAIT || state == CAPT)) begin
            poison    <= 1'b1;
         end
         if (state == WAIT && fill_done) cnt <= CW'(CAPTURE_DELAY);
         else if (state == CAPT)         cnt <= cnt - CW'(1);
         if (hit)          rdata <= lines[idx][rbit +: 32];
         else if (capture) rdata <= fill_line[rbit +: 32];
      end
   end
   // line data and tags need no reset: they are qualified by valid
   always_ff @(posedge clk) begin
      if (capture) begin
         lines[fidx] <= fill_line;
         tags[fidx]  <= fill_addr[23:OFF+IDX];
      end
   end
`ifdef XIP_CACHE_STATS_EN
   // saturating hit/miss counters, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit && hit_count != '1)   hit_count  <= hit_count + 32'd1;
         if (miss && miss_count != '1) miss_count <= miss_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_xip_line_cache.sv
// tb_xip_line_cache: directed self-checking bench for xip_line_cache with a simple controller model.
module tb_xip_line_cache;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req = 1'b0;
   logic [23:0]  addr = '0;
   logic         ready;
   logic [31:0]  rdata;
   logic         flush = 1'b0;
   logic         fill_rd;
   logic [23:0]  fill_addr;
   logic         fill_done = 1'b0;
   logic [127:0] fill_line = '1;
`ifdef XIP_CACHE_STATS_EN
   logic [31:0]  hit_count, miss_count;
`endif
   int checks = 0;
   int errors = 0;

   xip_line_cache dut (
      .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .ready(ready), .rdata(rdata),
      .flush(flush), .fill_rd(fill_rd), .fill_addr(fill_addr), .fill_done(fill_done),
      .fill_line(fill_line)
`ifdef XIP_CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // controller model: byte i = fill_addr[7:0] + i
   function automatic logic [127:0] pattern(input logic [23:0] fa);
      logic [127:0] l;
      for (int i = 0; i < 16; i++) l[8*i +: 8] = fa[7:0] + 8'(i);
      return l;
   endfunction

   task automatic miss_read(input string tag, input logic [23:0] a, input logic [23:0] fa,
                            input logic [31:0] exp, input bit fl_req, input bit fl_mid);
      req = 1'b1; addr = a; flush = fl_req;
      @(negedge clk); flush = 1'b0;
      chk({tag, "_fill_rd"}, 32'(fill_rd), 32'd1);
      chk({tag, "_fill_addr"}, 32'(fill_addr), 32'(fa));
      chk({tag, "_ready_early"}, 32'(ready), 32'd0);
      @(negedge clk);
      chk({tag, "_fill_rd_once"}, 32'(fill_rd), 32'd0);
      flush = fl_mid;
      @(negedge clk); flush = 1'b0;
      @(negedge clk);
      fill_done = 1'b1; fill_line = pattern(fa);
      @(negedge clk); fill_done = 1'b0;
      chk({tag, "_ready_d1"}, 32'(ready), 32'd0);
      @(negedge clk);
      chk({tag, "_ready_d2"}, 32'(ready), 32'd0);
      @(negedge clk);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      chk({tag, "_rdata"}, rdata, exp);
      req = 1'b0;
      @(negedge clk);
      chk({tag, "_ready_pulse"}, 32'(ready), 32'd0);
      fill_line = '1;
   endtask

   task automatic hit_read(input string tag, input logic [23:0] a, input logic [31:0] exp);
      req = 1'b1; addr = a;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      chk({tag, "_rdata"}, rdata, exp);
      chk({tag, "_no_fill"}, 32'(fill_rd), 32'd0);
      req = 1'b0;
      @(negedge clk);
      chk({tag, "_ready_pulse"}, 32'(ready), 32'd0);
   endtask

   initial begin
      @(negedge clk); @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_fill_rd", 32'(fill_rd), 32'd0);
      chk("rst_fill_addr", 32'(fill_addr), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      miss_read("cold", 24'h000104, 24'h000100, 32'h07060504, 1'b0, 1'b0);
      hit_read("hit", 24'h00010C, 32'h0F0E0D0C);
`ifdef XIP_CACHE_STATS_EN
      chk("stat_hit1", hit_count, 32'd1);
      chk("stat_miss1", miss_count, 32'd1);
`endif
      miss_read("evict", 24'h001104, 24'h001100, 32'h07060504, 1'b0, 1'b0);
      miss_read("reload", 24'h000100, 24'h000100, 32'h03020100, 1'b0, 1'b0);
      hit_read("rehit", 24'h000108, 32'h0B0A0908);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      @(negedge clk);
      miss_read("post_flush", 24'h000100, 24'h000100, 32'h03020100, 1'b0, 1'b0);
      miss_read("flush_req", 24'h000104, 24'h000100, 32'h07060504, 1'b1, 1'b0);
      hit_read("after_flush_req", 24'h000100, 32'h03020100);
      miss_read("poison", 24'h000200, 24'h000200, 32'h03020100, 1'b0, 1'b1);
      miss_read("poison_again", 24'h000200, 24'h000200, 32'h03020100, 1'b0, 1'b0);
      req = 1'b1; addr = 24'h000104;
      @(negedge clk);
      chk("midrst_fill_rd", 32'(fill_rd), 32'd1);
      @(negedge clk);
      rst_n = 1'b0; req = 1'b0;
      #1;
      chk("midrst_ready", 32'(ready), 32'd0);
      chk("midrst_fill_rd0", 32'(fill_rd), 32'd0);
      chk("midrst_fill_addr", 32'(fill_addr), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("postrst_ready", 32'(ready), 32'd0);
         chk("postrst_fill_rd", 32'(fill_rd), 32'd0);
      end
      miss_read("cold2", 24'h000104, 24'h000100, 32'h07060504, 1'b0, 1'b0);
`ifdef XIP_CACHE_STATS_EN
      chk("stat_hit_end", hit_count, 32'd0);
      chk("stat_miss_end", miss_count, 32'd1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
